// File: rtl/wb_host_pkg.sv
// Shared types and constants for the Wishbone host initiator.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package wb_host_pkg;

  localparam int WB_ADR_W = 32;
  localparam int WB_DAT_W = 32;
  localparam int WB_SEL_W = 4;

  // Read data returned with an aborted (timed-out) cycle.
  localparam logic [WB_DAT_W-1:0] WB_HOST_ERR_DATA = 32'h0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } wb_host_state_t;

endpackage

// File: rtl/wb_host_timeout.sv
// Ack watchdog: counts BUS cycles without an acknowledge and flags expiry.
// Latency: expire_o is combinational on the current count (fires on the TIMEOUT_CYCLES-th wait cycle).
// Backpressure: none; clear_i has priority over enable_i.
module wb_host_timeout
  import wb_host_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic wb_clk_i,
  input  logic wb_rst_i,
  input  logic clear_i,
  input  logic enable_i,
  output logic expire_o
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Restart from zero outside BUS, otherwise count each cycle spent waiting for ack.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // The count has already covered TIMEOUT_CYCLES-1 waits, so this edge is the last one.
  assign expire_o = enable_i && (cnt_q == CNT_LAST);

endmodule

// File: rtl/wb_host_master.sv
// Single-outstanding Wishbone classic initiator: command stream in, bus cycle, response stream out.
// Latency: cyc/stb one edge after accept; response one edge after sampled ack (or abort).
// Backpressure: cmd_ready_o only in IDLE; response held until rsp_ready_i. Watchdog: WB_HOST_TIMEOUT_EN.
module wb_host_master
  import wb_host_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  input  logic                cmd_valid_i,
  output logic                cmd_ready_o,
  input  logic                cmd_we_i,
  input  logic [WB_ADR_W-1:0] cmd_adr_i,
  input  logic [WB_DAT_W-1:0] cmd_dat_i,
  input  logic [WB_SEL_W-1:0] cmd_sel_i,
  output logic                rsp_valid_o,
  input  logic                rsp_ready_i,
  output logic [WB_DAT_W-1:0] rsp_dat_o,
  output logic                rsp_err_o,
  output logic                wb_cyc_o,
  output logic                wb_stb_o,
  output logic                wb_we_o,
  output logic [WB_SEL_W-1:0] wb_sel_o,
  output logic [WB_ADR_W-1:0] wb_adr_o,
  output logic [WB_DAT_W-1:0] wb_dat_o,
  input  logic                wb_ack_i,
  input  logic [WB_DAT_W-1:0] wb_dat_i
);

  // A one-cycle watchdog window cannot be distinguished from a normal ack wait.
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("wb_host_master: TIMEOUT_CYCLES must be at least 2");
  end

  wb_host_state_t      state_q, state_d;
  logic                cyc_q, cyc_d;
  logic                stb_q, stb_d;
  logic                we_q, we_d;
  logic [WB_SEL_W-1:0] sel_q, sel_d;
  logic [WB_ADR_W-1:0] adr_q, adr_d;
  logic [WB_DAT_W-1:0] dat_q, dat_d;
  logic                rsp_vld_q, rsp_vld_d;
  logic [WB_DAT_W-1:0] rsp_dat_q, rsp_dat_d;
  logic                to_expire;
  logic                in_bus;

  assign in_bus = (state_q == ST_BUS);

`ifdef WB_HOST_TIMEOUT_EN
  logic rsp_err_q;

  wb_host_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .wb_clk_i (wb_clk_i),
    .wb_rst_i (wb_rst_i),
    .clear_i  (!in_bus),
    .enable_i (in_bus && !wb_ack_i),
    .expire_o (to_expire)
  );

  // Error flag: an ack on the expiry edge wins, so only a wait without ack sets it.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      rsp_err_q <= 1'b0;
    end else if (in_bus) begin
      if (wb_ack_i) begin
        rsp_err_q <= 1'b0;
      end else if (to_expire) begin
        rsp_err_q <= 1'b1;
      end
    end
  end

  assign rsp_err_o = rsp_err_q;
`else
  assign to_expire = 1'b0;
  assign rsp_err_o = 1'b0;
`endif

  // Next-state and datapath: capture command in IDLE, wait for ack/abort in BUS, hold in RESP.
  always_comb begin
    state_d   = state_q;
    cyc_d     = cyc_q;
    stb_d     = stb_q;
    we_d      = we_q;
    sel_d     = sel_q;
    adr_d     = adr_q;
    dat_d     = dat_q;
    rsp_vld_d = rsp_vld_q;
    rsp_dat_d = rsp_dat_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid_i) begin
          we_d    = cmd_we_i;
          sel_d   = cmd_sel_i;
          adr_d   = cmd_adr_i;
          dat_d   = cmd_dat_i;
          cyc_d   = 1'b1;
          stb_d   = 1'b1;
          state_d = ST_BUS;
        end
      end
      ST_BUS: begin
        if (wb_ack_i) begin
          cyc_d     = 1'b0;
          stb_d     = 1'b0;
          we_d      = 1'b0;
          rsp_dat_d = we_q ? '0 : wb_dat_i;
          rsp_vld_d = 1'b1;
          state_d   = ST_RESP;
        end else if (to_expire) begin
          cyc_d     = 1'b0;
          stb_d     = 1'b0;
          we_d      = 1'b0;
          rsp_dat_d = WB_HOST_ERR_DATA;
          rsp_vld_d = 1'b1;
          state_d   = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready_i) begin
          rsp_vld_d = 1'b0;
          state_d   = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs; reset drops everything asynchronously.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q   <= ST_IDLE;
      cyc_q     <= 1'b0;
      stb_q     <= 1'b0;
      we_q      <= 1'b0;
      sel_q     <= '0;
      adr_q     <= '0;
      dat_q     <= '0;
      rsp_vld_q <= 1'b0;
      rsp_dat_q <= '0;
    end else begin
      state_q   <= state_d;
      cyc_q     <= cyc_d;
      stb_q     <= stb_d;
      we_q      <= we_d;
      sel_q     <= sel_d;
      adr_q     <= adr_d;
      dat_q     <= dat_d;
      rsp_vld_q <= rsp_vld_d;
      rsp_dat_q <= rsp_dat_d;
    end
  end

  // IDLE is the only state that accepts; no bypass from RESP straight into a new cycle.
  assign cmd_ready_o = (state_q == ST_IDLE);
  assign rsp_valid_o = rsp_vld_q;
  assign rsp_dat_o   = rsp_dat_q;
  assign wb_cyc_o    = cyc_q;
  assign wb_stb_o    = stb_q;
  assign wb_we_o     = we_q;
  assign wb_sel_o    = sel_q;
  assign wb_adr_o    = adr_q;
  assign wb_dat_o    = dat_q;

endmodule

// File: tb/tb_wb_host_master.sv
// Bench for wb_host_master: directed cases plus random traffic against a word-memory model.
// Latency: slave ack latency is programmable per transaction (0 = combinational ack).
// Backpressure: response stream is stalled for a random number of cycles.
module tb_wb_host_master;

  localparam int TO = 8;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i;
  logic        cmd_valid_i, cmd_ready_o, cmd_we_i;
  logic [31:0] cmd_adr_i, cmd_dat_i;
  logic [3:0]  cmd_sel_i;
  logic        rsp_valid_o, rsp_ready_i, rsp_err_o;
  logic [31:0] rsp_dat_o;
  logic        wb_cyc_o, wb_stb_o, wb_we_o;
  logic [3:0]  wb_sel_o;
  logic [31:0] wb_adr_o, wb_dat_o;
  logic        wb_ack_i;
  logic [31:0] wb_dat_i;

  int total = 0;
  int bad   = 0;

  // Slave side: latency in cycles after the first stb cycle; negative means never ack.
  int slave_lat = -1;
  int wcnt      = 0;
  bit [31:0] slave_mem [4];
  // Reference model: what the slave memory must contain after each command.
  bit [31:0] ref_mem [4];

  always #5 wb_clk_i = ~wb_clk_i;

  wb_host_master #(.TIMEOUT_CYCLES(TO)) dut (
    .wb_clk_i    (wb_clk_i),
    .wb_rst_i    (wb_rst_i),
    .cmd_valid_i (cmd_valid_i),
    .cmd_ready_o (cmd_ready_o),
    .cmd_we_i    (cmd_we_i),
    .cmd_adr_i   (cmd_adr_i),
    .cmd_dat_i   (cmd_dat_i),
    .cmd_sel_i   (cmd_sel_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_ready_i (rsp_ready_i),
    .rsp_dat_o   (rsp_dat_o),
    .rsp_err_o   (rsp_err_o),
    .wb_cyc_o    (wb_cyc_o),
    .wb_stb_o    (wb_stb_o),
    .wb_we_o     (wb_we_o),
    .wb_sel_o    (wb_sel_o),
    .wb_adr_o    (wb_adr_o),
    .wb_dat_o    (wb_dat_o),
    .wb_ack_i    (wb_ack_i),
    .wb_dat_i    (wb_dat_i)
  );

  assign wb_ack_i = wb_cyc_o && wb_stb_o && (slave_lat >= 0) && (wcnt == slave_lat);
  assign wb_dat_i = slave_mem[wb_adr_o[3:2]];

  // Slave wait counter and byte-lane write into its memory on the ack edge.
  always @(posedge wb_clk_i) begin
    wcnt <= (wb_cyc_o && wb_stb_o && !wb_ack_i) ? wcnt + 1 : 0;
    if (wb_ack_i && wb_we_o) begin
      for (int b = 0; b < 4; b++)
        if (wb_sel_o[b]) slave_mem[wb_adr_o[3:2]][8*b +: 8] <= wb_dat_o[8*b +: 8];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present one command and return at the negedge following the accepting edge.
  task automatic start_cmd(input bit we, input logic [31:0] adr, input logic [31:0] dat,
                           input logic [3:0] sel);
    int w;
    cmd_we_i = we; cmd_adr_i = adr; cmd_dat_i = dat; cmd_sel_i = sel;
    cmd_valid_i = 1'b1;
    w = 0;
    while (cmd_ready_o !== 1'b1 && w < 50) begin
      @(negedge wb_clk_i);
      w++;
    end
    chk("cmd_ready_idle", cmd_ready_o, 1'b1);
    @(negedge wb_clk_i);
    cmd_valid_i = 1'b0;
  endtask

  // Full transaction with checks on bus duration, stability, response and handshake.
  task automatic txn(input bit we, input logic [31:0] adr, input logic [31:0] dat,
                     input logic [3:0] sel, input int lat, input int bp, input bit to_exp);
    int cyc_n;
    int idx;
    logic [31:0] exp_dat;
    idx = int'(adr[3:2]);
    slave_lat = lat;
    rsp_ready_i = (bp == 0);
    start_cmd(we, adr, dat, sel);
    cyc_n = 0;
    while (wb_cyc_o === 1'b1 && cyc_n < 64) begin
      chk("bus_stb", wb_stb_o, 1'b1);
      chk("bus_we", wb_we_o, we);
      chk("bus_adr", wb_adr_o, adr);
      chk("bus_dat", wb_dat_o, dat);
      chk("bus_sel", wb_sel_o, sel);
      chk("bus_cmd_ready", cmd_ready_o, 1'b0);
      chk("bus_rsp_valid", rsp_valid_o, 1'b0);
      cyc_n++;
      @(negedge wb_clk_i);
    end
    chk("cyc_cycles", cyc_n, to_exp ? TO : lat + 1);
    if (to_exp) begin
      exp_dat = 32'h0;
    end else if (we) begin
      exp_dat = 32'h0;
      for (int b = 0; b < 4; b++)
        if (sel[b]) ref_mem[idx][8*b +: 8] = dat[8*b +: 8];
    end else begin
      exp_dat = ref_mem[idx];
    end
    chk("rsp_valid", rsp_valid_o, 1'b1);
    chk("rsp_err", rsp_err_o, to_exp);
    chk("rsp_dat", rsp_dat_o, exp_dat);
    chk("end_stb", wb_stb_o, 1'b0);
    chk("end_we", wb_we_o, 1'b0);
    chk("end_adr_kept", wb_adr_o, adr);
    chk("end_dat_kept", wb_dat_o, dat);
    for (int i = 0; i < bp; i++) begin
      cmd_valid_i = 1'b1;  // a queued command must not start while the response is pending
      @(negedge wb_clk_i);
      chk("bp_valid", rsp_valid_o, 1'b1);
      chk("bp_dat", rsp_dat_o, exp_dat);
      chk("bp_err", rsp_err_o, to_exp);
      chk("bp_cmd_ready", cmd_ready_o, 1'b0);
      chk("bp_no_cyc", wb_cyc_o, 1'b0);
    end
    rsp_ready_i = 1'b1;
    @(negedge wb_clk_i);
    cmd_valid_i = 1'b0;
    rsp_ready_i = 1'b0;
    chk("hs_valid_low", rsp_valid_o, 1'b0);
    chk("hs_cmd_ready", cmd_ready_o, 1'b1);
    chk("hs_no_cyc", wb_cyc_o, 1'b0);
    if (we && !to_exp) chk("slave_mem", slave_mem[idx], ref_mem[idx]);
  endtask

  // Hard stop in case the sequence wedges.
  initial begin
    #500000;
    $display("FAIL watchdog timer expired");
    $fatal(1, "bench watchdog");
  end

  initial begin
    logic [31:0] a, d;
    logic [3:0]  s;
    int          idx;
    wb_rst_i = 1'b1;
    cmd_valid_i = 1'b0; cmd_we_i = 1'b0; cmd_adr_i = '0; cmd_dat_i = '0; cmd_sel_i = '0;
    rsp_ready_i = 1'b0;
    repeat (2) @(negedge wb_clk_i);
    chk("rst_cmd_ready", cmd_ready_o, 1'b1);
    chk("rst_cyc", wb_cyc_o, 1'b0);
    chk("rst_stb", wb_stb_o, 1'b0);
    chk("rst_we", wb_we_o, 1'b0);
    chk("rst_adr", wb_adr_o, 32'h0);
    chk("rst_dat", wb_dat_o, 32'h0);
    chk("rst_sel", wb_sel_o, 4'h0);
    chk("rst_rsp_valid", rsp_valid_o, 1'b0);
    chk("rst_rsp_dat", rsp_dat_o, 32'h0);
    chk("rst_rsp_err", rsp_err_o, 1'b0);
    wb_rst_i = 1'b0;
    @(negedge wb_clk_i);
    chk("post_rst_cmd_ready", cmd_ready_o, 1'b1);

    // Write then read back with a registered-ack slave.
    txn(1'b1, 32'h3000_0000, 32'hFFFF_FFFF, 4'hF, 1, 0, 1'b0);
    txn(1'b0, 32'h3000_0000, 32'h0000_0000, 4'hF, 1, 0, 1'b0);
    // Response backpressure for 5 cycles, then an immediately following command.
    txn(1'b0, 32'h3000_0000, 32'h0000_0000, 4'hF, 1, 5, 1'b0);
    txn(1'b1, 32'h3000_0004, 32'h1234_5678, 4'hF, 0, 0, 1'b0);

`ifdef WB_HOST_TIMEOUT_EN
    // Slave never acks: abort after TO cycles.
    txn(1'b0, 32'h3000_0008, 32'h0, 4'hF, -1, 2, 1'b1);
`else
    // Slave never acks: cycle stays open indefinitely.
    slave_lat = -1;
    start_cmd(1'b0, 32'h3000_0008, 32'h0, 4'hF);
    repeat (1000) @(negedge wb_clk_i);
    chk("noto_cyc", wb_cyc_o, 1'b1);
    chk("noto_stb", wb_stb_o, 1'b1);
    chk("noto_rsp_valid", rsp_valid_o, 1'b0);
    wb_rst_i = 1'b1;
    @(negedge wb_clk_i);
    wb_rst_i = 1'b0;
    @(negedge wb_clk_i);
`endif

    // Ack lands on the last watchdog cycle: the ack wins.
    txn(1'b0, 32'h3000_0004, 32'h0, 4'hF, TO - 1, 0, 1'b0);

    // Reset one cycle after acceptance must clear outputs before the next edge.
    slave_lat = -1;
    start_cmd(1'b0, 32'h3000_000C, 32'h0, 4'hF);
    @(posedge wb_clk_i);
    #2;
    wb_rst_i = 1'b1;
    #1;
    chk("arst_cyc", wb_cyc_o, 1'b0);
    chk("arst_stb", wb_stb_o, 1'b0);
    chk("arst_rsp_valid", rsp_valid_o, 1'b0);
    @(negedge wb_clk_i);
    wb_rst_i = 1'b0;
    @(negedge wb_clk_i);
    chk("arst_cmd_ready", cmd_ready_o, 1'b1);
    chk("arst_cyc_after", wb_cyc_o, 1'b0);

    // Random traffic over four words with random latency, byte selects and backpressure.
    for (int i = 0; i < 24; i++) begin
      idx = $urandom_range(0, 3);
      a = 32'h3000_0000 | (32'(idx) << 2);
      d = $urandom;
      s = 4'($urandom_range(0, 15));
      txn(1'($urandom_range(0, 1)), a, d, s, $urandom_range(0, 3), $urandom_range(0, 3), 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
